// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_pkg
// Description : Shared types and constants for the sequential binary-to-BCD
//               converter (FSM state encoding, BCD digit width, add-3
//               correction threshold).
// Revision    : 1.0 - initial release
// ============================================================================
package bin2bcd_pkg;

    // Converter FSM states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of one packed BCD digit.
    localparam int BCD_DIGIT_W = 4;

    // Digits at or above this value get +3 before each shift.
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

endpackage : bin2bcd_pkg
`default_nettype wire

// File: rtl/bcd_add3_cell.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3_cell
// Description : Combinational double-dabble correction for one BCD digit:
//               o_digit = (i_digit >= 5) ? i_digit + 3 : i_digit.
//               The result stays within the digit; there is no carry out.
// Ports       : i_digit  [3:0]  scratch digit before the shift
//               o_digit  [3:0]  corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3_cell
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // A legal digit here is 0..9, so the sum tops out at 12 and fits 4 bits.
    assign o_digit = (i_digit >= ADD3_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_add3_cell
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential binary-to-BCD converter (shift-add-3 / double
//               dabble). One binary bit is consumed per clock; a conversion
//               takes BIN_W+2 cycles from accepting edge to the next
//               possible acceptance.
// Parameters  : BIN_W   width of the binary operand
//               DIGITS  number of 4-bit BCD output digits
// Ports       : clk      system clock, rising edge
//               rst_n    asynchronous active-low reset
//               start    conversion request, sampled only in IDLE
//               bin_in   operand, captured on the accepting edge
//               busy     high whenever the FSM is not in IDLE
//               done     one-cycle pulse when bcd_out is updated
//               bcd_out  packed BCD result, digit 0 (units) at [3:0]
//               ovf      (BIN2BCD_OVF_EN only) result exceeded 10^DIGITS-1
// Build macro : BIN2BCD_OVF_EN - adds the ovf port and sticky overflow flag;
//               without it, results silently truncate to DIGITS digits.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
`ifdef BIN2BCD_OVF_EN
    ,
    output logic                          ovf
`endif
);

    localparam int c_scr_w = BCD_DIGIT_W * DIGITS;
    localparam int c_cnt_w = $clog2(BIN_W + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(BIN_W);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [c_scr_w-1:0]   r_bcd;
    logic [c_scr_w-1:0]   r_scratch;
    logic [BIN_W-1:0]     r_shreg;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_scr_w-1:0]   w_adj;

    // Per-digit add-3 correction applied to the scratch before each shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3_cell u_cell (
            .i_digit (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BIN2BCD_OVF_EN
    logic r_ovf_flag;
    logic r_ovf;
`else
    // The bit leaving the top digit is intentionally discarded.
    logic w_unused_top;
    assign w_unused_top = w_adj[c_scr_w-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_scratch  <= '0;
            r_shreg    <= '0;
            r_count    <= '0;
`ifdef BIN2BCD_OVF_EN
            r_ovf_flag <= 1'b0;
            r_ovf      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shreg    <= bin_in;
                        r_scratch  <= '0;
                        r_count    <= c_cnt_load;
                        r_busy     <= 1'b1;
                        r_state    <= SHIFT;
`ifdef BIN2BCD_OVF_EN
                        r_ovf_flag <= 1'b0;
                        r_ovf      <= 1'b0;
`endif
                    end
                end

                SHIFT: begin
                    // Corrected scratch shifts left; operand MSB enters at bit 0.
                    r_scratch <= {w_adj[c_scr_w-2:0], r_shreg[BIN_W-1]};
                    r_shreg   <= r_shreg << 1;
                    r_count   <= r_count - c_cnt_last;
`ifdef BIN2BCD_OVF_EN
                    r_ovf_flag <= r_ovf_flag | w_adj[c_scr_w-1];
`endif
                    if (r_count == c_cnt_last) begin
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    r_bcd   <= r_scratch;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
`ifdef BIN2BCD_OVF_EN
                    r_ovf   <= r_ovf_flag;
`endif
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd;
`ifdef BIN2BCD_OVF_EN
    assign ovf     = r_ovf;
`endif

endmodule : bin2bcd_seq
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq. Results are compared
//               against a decimal-arithmetic reference (value mod 10 per
//               digit). With BIN2BCD_OVF_EN the DUT is built with DIGITS=2
//               and the overflow output is checked as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    localparam int BIN_W = 8;
`ifdef BIN2BCD_OVF_EN
    localparam int DIGITS = 2;
`else
    localparam int DIGITS = 3;
`endif
    localparam int OUT_W = 4 * DIGITS;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             start  = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] bcd_out;
`ifdef BIN2BCD_OVF_EN
    logic             ovf;
`endif

    int total = 0;
    int bad   = 0;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
`ifdef BIN2BCD_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Decimal digits of v, truncated to DIGITS digits, packed 4 bits each.
    function automatic logic [31:0] ref_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | (32'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_ovf(input int v);
        int lim;
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        return (v >= lim) ? 32'd1 : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion of v. If accepted=1 the accepting edge has already
    // happened. spur>=0 holds start high with bin_in=spur while busy.
    // chain=1 requests nxt on the cycle right after done.
    task automatic run_conv(input int v, input bit accepted, input int spur,
                            input bit chain, input int nxt);
        int  edges;
        int  busy_cnt;
        bit  seen;
        if (!accepted) begin
            start  = 1'b1;
            bin_in = BIN_W'(v);
            @(posedge clk); #1;
        end
        start    = 1'b0;
        bin_in   = BIN_W'($urandom);
        busy_cnt = busy ? 1 : 0;
        edges    = 0;
        seen     = 1'b0;
        while (!seen && edges < 30) begin
            if (spur >= 0) begin
                start  = 1'b1;
                bin_in = BIN_W'(spur);
            end
            @(posedge clk); #1;
            edges++;
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(edges), 32'(BIN_W + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(BIN_W + 1));
        check("busy_at_done", 32'(busy), 32'd0);
        check("bcd_out", 32'(bcd_out), ref_bcd(v));
`ifdef BIN2BCD_OVF_EN
        check("ovf", 32'(ovf), ref_ovf(v));
`endif
        if (chain) begin
            start  = 1'b1;
            bin_in = BIN_W'(nxt);
        end
        @(posedge clk); #1;
        check("done_single", 32'(done), 32'd0);
        check("bcd_hold", 32'(bcd_out), ref_bcd(v));
        check("busy_after", 32'(busy), 32'(chain));
`ifdef BIN2BCD_OVF_EN
        check("ovf_after", 32'(ovf), chain ? 32'd0 : ref_ovf(v));
`endif
    endtask

    initial begin
        int v;
        int w;
        bit ch;
        bit got_done;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
`ifdef BIN2BCD_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: zero operand
        run_conv(0, 1'b0, -1, 1'b0, 0);
        // 2: max operand
        run_conv(255, 1'b0, -1, 1'b0, 0);
        // 3: start held while busy (through DONE) is ignored
        run_conv(99, 1'b0, 7, 1'b0, 0);

        // 4: reset during SHIFT cycle 4
        start  = 1'b1;
        bin_in = 8'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'd0);
        got_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) got_done = 1'b1;
            if (i == 2) rst_n = 1'b1;
        end
        check("abort_no_done", 32'(got_done), 32'd0);
        check("abort_bcd_after", 32'(bcd_out), 32'd0);
        run_conv(42, 1'b0, -1, 1'b0, 0);

        // 5: back-to-back 12 then 87
        run_conv(12, 1'b0, -1, 1'b1, 87);
        run_conv(87, 1'b1, -1, 1'b0, 0);

        // 6: overflow case then in-range case (overflow only with DIGITS=2)
        run_conv(150, 1'b0, -1, 1'b0, 0);
        run_conv(99, 1'b0, -1, 1'b0, 0);

        // Randomized operands, some chained back-to-back
        v  = int'($urandom_range(0, 255));
        ch = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bit nch;
            w   = int'($urandom_range(0, 255));
            nch = 1'($urandom_range(0, 1));
            run_conv(v, ch, -1, nch, w);
            ch = nch;
            v  = w;
        end
        if (ch) run_conv(v, 1'b1, -1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bin2bcd_seq
`default_nettype wire
